key_cmd_gen: RTL

KEY_CMD_GEN -- requirements
Module: key_cmd_gen

---
 rtl/game_pkg.sv | 39 +++
 rtl/gravity_timer.sv | 34 +++
 rtl/key_cmd_gen.sv | 114 +++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared keyboard constants and decoded-key type for the falling-block game.
package game_pkg;

  localparam int unsigned KEYCODE_W = 8;
  localparam int unsigned CNT_W     = 8;

  localparam logic [KEYCODE_W-1:0] KC_NONE   = 8'h00;
  localparam logic [KEYCODE_W-1:0] KC_LEFT   = 8'h04;
  localparam logic [KEYCODE_W-1:0] KC_RIGHT  = 8'h07;
  localparam logic [KEYCODE_W-1:0] KC_ROTATE = 8'h1A;
  localparam logic [KEYCODE_W-1:0] KC_DOWN   = 8'h16;

  typedef enum logic [2:0] {
    KEY_NONE,
    KEY_LEFT,
    KEY_RIGHT,
    KEY_ROTATE,
    KEY_DOWN
  } key_t;

  // Unrecognised keycodes collapse to KEY_NONE.
  function automatic key_t decode_key(input logic [KEYCODE_W-1:0] code);
    key_t k;
    case (code)
      KC_NONE:   k = KEY_NONE;
      KC_LEFT:   k = KEY_LEFT;
      KC_RIGHT:  k = KEY_RIGHT;
      KC_ROTATE: k = KEY_ROTATE;
      KC_DOWN:   k = KEY_DOWN;
      default:   k = KEY_NONE;
    endcase
    return k;
  endfunction

  function automatic logic is_move(input key_t k);
    return (k == KEY_LEFT) || (k == KEY_RIGHT);
  endfunction

endpackage

// File: rtl/gravity_timer.sv
// Free-running frame counter that pulses tick once every `period` frames.
module gravity_timer
  import game_pkg::*;
(
  input  logic             frame_clk,
  input  logic             Reset,
  input  logic             enable,
  input  logic [CNT_W-1:0] period,
  output logic             tick
);

  logic [CNT_W-1:0] count;
  logic             at_end_c;

  // A shrinking period can leave count past the new end; fire and wrap at once.
  assign at_end_c = (period <= CNT_W'(1)) || (count >= (period - CNT_W'(1)));

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      count <= '0;
      tick  <= 1'b0;
    end else if (!enable) begin
      count <= '0;
      tick  <= 1'b0;
    end else if (at_end_c) begin
      count <= '0;
      tick  <= 1'b1;
    end else begin
      count <= count + CNT_W'(1);
      tick  <= 1'b0;
    end
  end

endmodule

// File: rtl/key_cmd_gen.sv
// Turns a held USB HID keycode into move/rotate pulses with delayed auto-repeat,
// plus gravity ticks whose rate speeds up while soft drop is held.
module key_cmd_gen
  import game_pkg::*;
#(
  parameter int unsigned DAS_DELAY        = 16,
  parameter int unsigned ARR_PERIOD       = 4,
  parameter int unsigned GRAVITY_PERIOD   = 50,
  parameter int unsigned SOFT_DROP_PERIOD = 3
) (
  input  logic                 frame_clk,
  input  logic                 Reset,
  input  logic [KEYCODE_W-1:0] keycode,
  input  logic                 enable,
  output logic                 move_left,
  output logic                 move_right,
  output logic                 rotate,
  output logic                 gravity_tick,
  output logic                 soft_drop
);

  localparam logic [CNT_W-1:0] DAS_LAST = CNT_W'(DAS_DELAY - 1);
  localparam logic [CNT_W-1:0] ARR_LAST = CNT_W'(ARR_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } move_state_t;

  move_state_t      state;
  key_t             prev_key;
  logic [CNT_W-1:0] frame_cnt;

  key_t             key_c;
  logic             down_c;
  logic [CNT_W-1:0] grav_period_c;

  assign key_c         = decode_key(keycode);
  assign down_c        = enable && (key_c == KEY_DOWN);
  assign grav_period_c = down_c ? CNT_W'(SOFT_DROP_PERIOD) : CNT_W'(GRAVITY_PERIOD);

  gravity_timer u_gravity_timer (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .enable    (enable),
    .period    (grav_period_c),
    .tick      (gravity_tick)
  );

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      prev_key   <= KEY_NONE;
      frame_cnt  <= '0;
      move_left  <= 1'b0;
      move_right <= 1'b0;
      rotate     <= 1'b0;
      soft_drop  <= 1'b0;
    end else begin
      move_left  <= 1'b0;
      move_right <= 1'b0;
      rotate     <= 1'b0;
      soft_drop  <= down_c;

      // Forgetting the previous key makes a key held across enable a fresh press.
      if (!enable) begin
        state     <= IDLE;
        prev_key  <= KEY_NONE;
        frame_cnt <= '0;
      end else begin
        prev_key <= key_c;
        rotate   <= (key_c == KEY_ROTATE) && (prev_key != KEY_ROTATE);

        if (is_move(key_c) && (key_c != prev_key)) begin
          move_left  <= (key_c == KEY_LEFT);
          move_right <= (key_c == KEY_RIGHT);
          frame_cnt  <= '0;
          state      <= DELAY;
        end else if (!is_move(key_c)) begin
          frame_cnt <= '0;
          state     <= IDLE;
        end else begin
          case (state)
            DELAY: begin
              if (frame_cnt >= DAS_LAST) begin
                move_left  <= (key_c == KEY_LEFT);
                move_right <= (key_c == KEY_RIGHT);
                frame_cnt  <= '0;
                state      <= REPEAT;
              end else begin
                frame_cnt <= frame_cnt + CNT_W'(1);
              end
            end
            REPEAT: begin
              if (frame_cnt >= ARR_LAST) begin
                move_left  <= (key_c == KEY_LEFT);
                move_right <= (key_c == KEY_RIGHT);
                frame_cnt  <= '0;
              end else begin
                frame_cnt <= frame_cnt + CNT_W'(1);
              end
            end
            default: begin
              frame_cnt <= '0;
              state     <= IDLE;
            end
          endcase
        end
      end
    end
  end

endmodule
